cla_adder_pipe: RTL and testbench
=================================

// Module: cla_adder_pipe
// PURPOSE
//  Parametrised, 2-stage pipelined carry-lookahead add/subtract unit with valid/ready handshake.
//  Generalises the 4-bit CLA adder: WIDTH is any multiple of GROUP, subtract mode, signed overflow, backpressure.
//  Sits between an operand producer and a result consumer in the datapath.
//  Throughput is one operation per clock when out_ready is held high.
// PARAMETERS
//  WIDTH  16  operand/sum width in bits; must be a multiple of GROUP, range 4..64
//  GROUP   4  bits per lookahead slice; fixed at 4 in this revision (elaboration error otherwise)
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operand beat valid
//  in_ready   out  1      unit can accept a beat this cycle
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry-in; ignored when op_sub=1
//  op_sub     in   1      0: a+b+cin   1: a-b (a + ~b + 1)
//  out_valid  out  1      result beat valid
//  out_ready  in   1      consumer accepts the result
//  sum        out  WIDTH  result, modulo 2^WIDTH
//  cout       out  1      carry out of the MSB (sub: 1 = no borrow)
//  ovf        out  1      two's-complement signed overflow
// BEHAVIOUR
//  - Reset (async assert, sync release): s1_valid=0, s2_valid=0; out_valid=0, sum=0, cout=0, ovf=0, in_ready=1.
//  - Handshake: a transfer occurs when valid&&ready on the same edge; payload is held stable while valid&&!ready.
//  - Stage 1 (on in transfer): latch a, b_eff = b ^ {WIDTH{op_sub}}, c_eff = op_sub ? 1 : cin.
//    Compute per-slice P/G (group propagate/generate) and register them.
//  - Stage 2: the lookahead tree over WIDTH/GROUP slices forms the slice carries; per-bit sums are registered.
//    cout = carry out of bit WIDTH-1; ovf = carry into MSB ^ carry out of MSB.
//  - Latency: out_valid rises exactly 2 cycles after an accepted input when the pipe is unstalled.
//  - Advance rules:
//      s2_load = s1_valid && (!s2_valid || out_ready)
//      s1_load = in_valid && in_ready
//      in_ready = !s1_valid || s2_load   (combinational from out_ready; no path from in_valid)
//  - Simultaneous in transfer and s1->s2 move in one cycle: both occur and no beat is lost or duplicated.
//  - Full pipe with out_ready=0: in_ready=0 and all registers hold.
//  - Wrap-around: 0xFFFF+0x0001 -> sum=0, cout=1. Subtract of equal operands -> sum=0, cout=1, ovf=0.
//  - Reset mid-operation: in-flight beats are discarded with no partial output; first result follows 2 cycles after the first post-reset accept.
//  - No X propagation: sum/cout/ovf hold their last value when out_valid=0.
// STRUCTURE
//  - cla_pkg:
//      CLA_GROUP=4
//      function num_groups(width)
//      typedef of the slice P/G pair
//      localparam OP_ADD=1'b0, OP_SUB=1'b1
//  - Sub-module cla_slice4: combinational 4-bit slice. Inputs a[3:0], b[3:0], ci; outputs s[3:0], P, G.
//    Instantiated WIDTH/GROUP times through a generate loop.
//  - Top-level group-carry lookahead: c[k+1] = G[k] | P[k]&c[k], flattened per level.
//  - Pipeline control lives in the top level only.
// TESTING
//  1. WIDTH=16: a=0x0001, b=0x0002, cin=1, op_sub=0 -> two cycles later sum=0x0004, cout=0, ovf=0.
//  2. a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0; a=0x7FFF, b=0x0001 -> sum=0x8000, ovf=1.
//  3. op_sub=1: a=0x000A, b=0x0004, cin=1 (ignored) -> sum=0x0006, cout=1; a=0x8000, b=0x0001 -> sum=0x7FFF, ovf=1.
//  4. Back-to-back stream of 8 beats, out_ready toggling 1,0,0,1,... -> results emerge in order with no drop or duplicate;
//     in_ready=0 exactly while both stages are full and out_ready=0.
//  5. rst_n pulled low mid-stream with 2 beats in flight -> out_valid=0 immediately; no stale result after release.
//  6. WIDTH=4 instance, exhaustive a, b, cin, op_sub (1024 cases) against a behavioural +/- model -> zero mismatches.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared constants, slice P/G type and helpers for the pipelined carry-lookahead adder.
package cla_pkg;

  localparam int CLA_GROUP = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef struct packed {
    logic p;
    logic g;
  } pg_t;

  function automatic int num_groups(input int width);
    return width / CLA_GROUP;
  endfunction

  // Group propagate/generate of one 4-bit slice; independent of the slice carry-in.
  function automatic pg_t slice_pg(input logic [CLA_GROUP-1:0] a, input logic [CLA_GROUP-1:0] b);
    logic [CLA_GROUP-1:0] gb;
    logic [CLA_GROUP-1:0] pb;
    pg_t                  r;
    gb  = a & b;
    pb  = a ^ b;
    r.p = &pb;
    r.g = gb[3] | (pb[3] & gb[2]) | (pb[3] & pb[2] & gb[1]) | (pb[3] & pb[2] & pb[1] & gb[0]);
    return r;
  endfunction

endpackage

// File: rtl/cla_slice4.sv
// Combinational 4-bit carry-lookahead slice: sum bits plus group propagate/generate.
module cla_slice4
  import cla_pkg::*;
(
  input  logic [CLA_GROUP-1:0] a,
  input  logic [CLA_GROUP-1:0] b,
  input  logic                 ci,
  output logic [CLA_GROUP-1:0] s,
  output logic                 p,
  output logic                 g
);

  logic [CLA_GROUP-1:0] gb;
  logic [CLA_GROUP-1:0] pb;
  logic [CLA_GROUP-1:0] c;

  assign gb = a & b;
  assign pb = a ^ b;

  assign c[0] = ci;
  assign c[1] = gb[0] | (pb[0] & ci);
  assign c[2] = gb[1] | (pb[1] & gb[0]) | (pb[1] & pb[0] & ci);
  assign c[3] = gb[2] | (pb[2] & gb[1]) | (pb[2] & pb[1] & gb[0]) | (pb[2] & pb[1] & pb[0] & ci);

  assign s = pb ^ c;
  assign p = &pb;
  assign g = gb[3] | (pb[3] & gb[2]) | (pb[3] & pb[2] & gb[1]) | (pb[3] & pb[2] & pb[1] & gb[0]);

endmodule

// File: rtl/cla_adder_pipe.sv
// Two-stage pipelined carry-lookahead add/subtract unit with valid/ready on both sides.
// Handshake: a beat moves when valid && ready at the same rising edge; the sender holds
// its payload stable while valid && !ready, and in_ready never depends on in_valid.
module cla_adder_pipe
  import cla_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NG = num_groups(WIDTH);

  generate
    if (GROUP != CLA_GROUP || (WIDTH % CLA_GROUP) != 0 || WIDTH < 4 || WIDTH > 64) begin : g_bad_params
      $error("cla_adder_pipe: GROUP must be 4 and WIDTH a multiple of 4 in 4..64");
    end
  endgenerate

  logic             s1_valid_q, s1_valid_d;
  logic             s2_valid_q, s2_valid_d;
  logic             s1_load, s2_load;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;
  pg_t  [NG-1:0]    pg_d, pg1_q;
  logic [WIDTH-1:0] a1_q, b1_q;
  logic             c1_q;
  logic [NG:0]      gc;
  logic [WIDTH-1:0] sum_d, sum_q;
  logic             cout_d, cout_q, ovf_d, ovf_q;
  logic [NG-1:0]    unused_slice_p, unused_slice_g;

  assign s2_load  = s1_valid_q && (!s2_valid_q || out_ready);
  assign in_ready = !s1_valid_q || s2_load;
  assign s1_load  = in_valid && in_ready;

  always_comb begin
    b_eff      = b ^ {WIDTH{op_sub == OP_SUB}};
    c_eff      = (op_sub == OP_SUB) ? 1'b1 : cin;
    pg_d       = '0;
    for (int k = 0; k < NG; k++) begin
      pg_d[k] = slice_pg(a[k*CLA_GROUP +: CLA_GROUP], b_eff[k*CLA_GROUP +: CLA_GROUP]);
    end
    s1_valid_d = s1_load || (s1_valid_q && !s2_load);
    s2_valid_d = s2_load || (s2_valid_q && !out_ready);
  end

  // Each slice carry is a flat sum of products over all lower slices, not a ripple chain.
  always_comb begin
    logic term;
    logic acc;
    term  = 1'b0;
    acc   = 1'b0;
    gc    = '0;
    gc[0] = c1_q;
    for (int k = 0; k < NG; k++) begin
      acc = c1_q;
      for (int m = 0; m <= k; m++) acc = acc & pg1_q[m].p;
      for (int j = 0; j <= k; j++) begin
        term = pg1_q[j].g;
        for (int m = j + 1; m <= k; m++) term = term & pg1_q[m].p;
        acc = acc | term;
      end
      gc[k+1] = acc;
    end
  end

  generate
    for (genvar k = 0; k < NG; k++) begin : g_slice
      cla_slice4 u_slice (
        .a  (a1_q[k*CLA_GROUP +: CLA_GROUP]),
        .b  (b1_q[k*CLA_GROUP +: CLA_GROUP]),
        .ci (gc[k]),
        .s  (sum_d[k*CLA_GROUP +: CLA_GROUP]),
        .p  (unused_slice_p[k]),
        .g  (unused_slice_g[k])
      );
    end
  endgenerate

  // Carry into the MSB is recovered from its sum bit, so no extra per-bit carry is exposed.
  assign cout_d = gc[NG];
  assign ovf_d  = gc[NG] ^ (sum_d[WIDTH-1] ^ a1_q[WIDTH-1] ^ b1_q[WIDTH-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      a1_q       <= '0;
      b1_q       <= '0;
      c1_q       <= 1'b0;
      pg1_q      <= '0;
      s2_valid_q <= 1'b0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      if (s1_load) begin
        a1_q  <= a;
        b1_q  <= b_eff;
        c1_q  <= c_eff;
        pg1_q <= pg_d;
      end
      if (s2_load) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
        ovf_q  <= ovf_d;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Bench for cla_adder_pipe: 16-bit vector table, stalled stream, mid-stream reset,
// and an exhaustive 4-bit instance, all checked through expected-result queues.
module tb_cla_adder_pipe;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 16-bit instance
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic [15:0] a = '0, b = '0, sum;
  logic        cin = 1'b0, op_sub = 1'b0, cout, ovf;

  // 4-bit instance
  logic       in_valid4 = 1'b0, in_ready4, out_valid4, out_ready4 = 1'b1;
  logic [3:0] a4 = '0, b4 = '0, sum4;
  logic       cin4 = 1'b0, op_sub4 = 1'b0, cout4, ovf4;

  cla_adder_pipe #(.WIDTH(16), .GROUP(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .op_sub(op_sub),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
  );

  cla_adder_pipe #(.WIDTH(4), .GROUP(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .cin(cin4), .op_sub(op_sub4),
    .out_valid(out_valid4), .out_ready(out_ready4), .sum(sum4), .cout(cout4), .ovf(ovf4)
  );

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [17:0] exp_q[$];
  logic [5:0]  exp4_q[$];
  logic [17:0] pending_exp  = '0;
  logic [5:0]  pending_exp4 = '0;
  int          inflight  = 0;
  int          inflight4 = 0;
  logic [17:0] e16;
  logic [5:0]  e4;
  logic        stream_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Behavioural reference: integer arithmetic, signed range test for overflow.
  function automatic logic [17:0] model(input int w, input int ua, input int ub, input int ci, input int sub);
    int          mask, half, sa, sb, u, r;
    logic        co, ov;
    logic [15:0] s;
    mask = (1 << w) - 1;
    half = 1 << (w - 1);
    sa = (ua >= half) ? ua - (1 << w) : ua;
    sb = (ub >= half) ? ub - (1 << w) : ub;
    if (sub != 0) begin
      u  = ua - ub;
      co = (ua >= ub);
      r  = sa - sb;
    end else begin
      u  = ua + ub + ci;
      co = (u > mask);
      r  = sa + sb + ci;
    end
    ov = (r > half - 1) || (r < -half);
    s  = 16'(u & mask);
    return {s, co, ov};
  endfunction

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      inflight = 0;
      exp_q.delete();
    end else begin
      chk("in_ready16", {31'd0, in_ready}, {31'd0, !(inflight == 2 && !out_ready)});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out16", {31'd0, out_valid}, 32'd0);
        end else begin
          e16 = exp_q.pop_front();
          chk("sum16",  {16'd0, sum},       {16'd0, e16[17:2]});
          chk("cout16", {31'd0, cout},      {31'd0, e16[1]});
          chk("ovf16",  {31'd0, ovf},       {31'd0, e16[0]});
        end
        inflight--;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(pending_exp);
        inflight++;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      inflight4 = 0;
      exp4_q.delete();
    end else begin
      chk("in_ready4", {31'd0, in_ready4}, {31'd0, !(inflight4 == 2 && !out_ready4)});
      if (out_valid4 && out_ready4) begin
        if (exp4_q.size() == 0) begin
          chk("unexpected_out4", {31'd0, out_valid4}, 32'd0);
        end else begin
          e4 = exp4_q.pop_front();
          chk("sum4",  {28'd0, sum4},  {28'd0, e4[5:2]});
          chk("cout4", {31'd0, cout4}, {31'd0, e4[1]});
          chk("ovf4",  {31'd0, ovf4},  {31'd0, e4[0]});
        end
        inflight4--;
      end
      if (in_valid4 && in_ready4) begin
        exp4_q.push_back(pending_exp4);
        inflight4++;
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic send16(input logic [15:0] ta, input logic [15:0] tb_, input logic tc,
                        input logic ts, input logic [17:0] te);
    logic acc;
    int   n;
    a = ta; b = tb_; cin = tc; op_sub = ts; pending_exp = te; in_valid = 1'b1;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) chk("send16_timeout", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic send4(input logic [3:0] ta, input logic [3:0] tb_, input logic tc,
                       input logic ts, input logic [5:0] te);
    logic acc;
    int   n;
    a4 = ta; b4 = tb_; cin4 = tc; op_sub4 = ts; pending_exp4 = te; in_valid4 = 1'b1;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready4;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) chk("send4_timeout", {31'd0, in_ready4}, 32'd1);
  endtask

  task automatic idle(input int n);
    in_valid  = 1'b0;
    in_valid4 = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    vecs[0]  = '{16'h0001, 16'h0002, 1'b1, 1'b0, 16'h0004, 1'b0, 1'b0};
    vecs[1]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3]  = '{16'h000A, 16'h0004, 1'b1, 1'b1, 16'h0006, 1'b1, 1'b0};
    vecs[4]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[5]  = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[6]  = '{16'h0000, 16'h0001, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};
    vecs[7]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[8]  = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
    vecs[9]  = '{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[10] = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1};
    vecs[11] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_sum",       {16'd0, sum},       32'd0);
    chk("rst_cout",      {31'd0, cout},      32'd0);
    chk("rst_ovf",       {31'd0, ovf},       32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_out_valid4", {31'd0, out_valid4}, 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Latency on an empty, unstalled pipe
    send16(vecs[0].a, vecs[0].b, vecs[0].cin, vecs[0].sub, {vecs[0].sum, vecs[0].cout, vecs[0].ovf});
    in_valid = 1'b0;
    @(negedge clk);
    chk("latency_early", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    chk("latency_on_time", {31'd0, out_valid}, 32'd1);
    @(posedge clk);
    #1;
    idle(2);

    // Table, back-to-back
    for (int i = 0; i < 12; i++) begin
      send16(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, {vecs[i].sum, vecs[i].cout, vecs[i].ovf});
    end
    idle(5);
    chk("table_drained", exp_q.size(), 32'd0);

    // Stream of 8 random beats under out_ready pattern 1,0,0,1
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          logic [15:0] ra, rb;
          logic        rc, rs;
          ra = 16'($urandom_range(0, 16'hFFFF));
          rb = 16'($urandom_range(0, 16'hFFFF));
          rc = 1'($urandom_range(0, 1));
          rs = 1'($urandom_range(0, 1));
          send16(ra, rb, rc, rs, model(16, int'(ra), int'(rb), int'(rc), int'(rs)));
        end
        in_valid    = 1'b0;
        stream_done = 1'b1;
      end
      begin
        for (int c = 0; c < 300 && !stream_done; c++) begin
          out_ready = ((c % 4) == 0) || ((c % 4) == 3);
          @(posedge clk);
          #1;
        end
      end
    join
    out_ready = 1'b1;
    idle(6);
    chk("stream_drained", exp_q.size(), 32'd0);

    // Reset with two beats in flight
    out_ready = 1'b0;
    send16(16'h1111, 16'h2222, 1'b0, 1'b0, model(16, 16'h1111, 16'h2222, 0, 0));
    send16(16'h3333, 16'h0001, 1'b0, 1'b1, model(16, 16'h3333, 16'h0001, 0, 1));
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_in_ready",  {31'd0, in_ready},  32'd1);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    idle(4);
    chk("no_stale_out", {31'd0, out_valid}, 32'd0);
    send16(16'hABCD, 16'h1111, 1'b1, 1'b0, model(16, 16'hABCD, 16'h1111, 1, 0));
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_early", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    chk("post_rst_on_time", {31'd0, out_valid}, 32'd1);
    @(posedge clk);
    #1;
    idle(3);
    chk("post_rst_drained", exp_q.size(), 32'd0);

    // Exhaustive 4-bit instance
    out_ready4 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        for (int c = 0; c < 2; c++) begin
          for (int s = 0; s < 2; s++) begin
            logic [17:0] m;
            m = model(4, i, j, c, s);
            send4(4'(i), 4'(j), 1'(c), 1'(s), {m[5:2], m[1], m[0]});
          end
        end
      end
    end
    idle(5);
    chk("exhaustive4_drained", exp4_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
